// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe: two-stage pipelined ALU with registered flags and valid/ready
// handshakes on both sides. It sits between the operand-issue logic and the
// result writeback path.
//
// Stage 1 registers the operands and the op select.
// Stage 2 registers the result and all flags.
// With no backpressure, a result appears two clock edges after its beat is
// accepted. Throughput is one beat per cycle.
//
// Optional feature: define ALU_STICKY_OF_EN to enable the sticky overflow
// flag. When the macro is undefined, sticky_of is tied low and sticky_clr is
// ignored.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat is valid
//   in_ready   out  1      block can accept an operand beat
//   in_a/in_b  in   WIDTH  operands
//   in_op      in   OP_W   000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD,
//                          101 SUB, 110 SLT, 111 SLTU
//   out_valid  out  1      result beat is valid
//   out_ready  in   1      downstream accepts the result beat
//   out_s      out  WIDTH  result
//   out_eq     out  1      a == b
//   out_carry  out  1      carry on ADD, not-borrow on SUB, else 0
//   out_of     out  1      signed overflow on ADD/SUB, else 0
//   out_zero   out  1      out_s == 0
//   sticky_clr in   1      clears sticky_of
//   sticky_of  out  1      sticky overflow flag
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_eq,
    output logic             out_carry,
    output logic             out_of,
    output logic             out_zero,
    input  logic             sticky_clr,
    output logic             sticky_of
);

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b110;
    localparam logic [OP_W-1:0] OP_SLTU = 3'b111;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [OP_W-1:0]  r_s1_op;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_s;
    logic             r_s2_eq;
    logic             r_s2_carry;
    logic             r_s2_of;
    logic             r_s2_zero;

    logic             w_s1_load;
    logic             w_s2_load;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_of;

    // A stage loads when empty or when its contents move on this same edge,
    // so a full pipeline with out_ready=1 still accepts a beat every cycle.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // SLT/SLTU reuse the subtractor: a - b decides the comparison.
    assign w_is_sub = (r_s1_op == OP_SUB) || (r_s1_op == OP_SLT) || (r_s1_op == OP_SLTU);
    assign w_b_eff  = w_is_sub ? ~r_s1_b : r_s1_b;
    assign w_sum    = {1'b0, r_s1_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_ovf    = (r_s1_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_of    = 1'b0;
        case (r_s1_op)
            OP_AND:  w_res = r_s1_a & r_s1_b;
            OP_OR:   w_res = r_s1_a | r_s1_b;
            OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            OP_NOR:  w_res = ~(r_s1_a | r_s1_b);
            OP_ADD, OP_SUB: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_of    = w_ovf;
            end
            // Signed less-than: sign of the difference corrected by overflow.
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            // Unsigned less-than: a borrow occurred (no carry out).
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, ~w_sum[WIDTH]};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= in_a;
                r_s1_b  <= in_b;
                r_s1_op <= in_op;
            end
        end
    end

    // Result registers only change when a new beat lands, so they hold
    // stable while stalled and after the last beat drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_s     <= '0;
            r_s2_eq    <= 1'b0;
            r_s2_carry <= 1'b0;
            r_s2_of    <= 1'b0;
            r_s2_zero  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_s     <= w_res;
                r_s2_eq    <= (r_s1_a == r_s1_b);
                r_s2_carry <= w_carry;
                r_s2_of    <= w_of;
                r_s2_zero  <= (w_res == '0);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_s     = r_s2_s;
    assign out_eq    = r_s2_eq;
    assign out_carry = r_s2_carry;
    assign out_of    = r_s2_of;
    assign out_zero  = r_s2_zero;

`ifdef ALU_STICKY_OF_EN
    logic r_sticky_of;

    // Set has priority over clear on a coincident edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_of <= 1'b0;
        end else if (r_s2_valid && out_ready && r_s2_of) begin
            r_sticky_of <= 1'b1;
        end else if (sticky_clr) begin
            r_sticky_of <= 1'b0;
        end
    end

    assign sticky_of = r_sticky_of;
`else
    logic w_unused_sticky_clr;

    assign w_unused_sticky_clr = sticky_clr;
    assign sticky_of           = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe: directed, self-checking bench for alu_pipe (WIDTH=32).
// Inputs change on the falling edge of clk, and outputs are sampled on the
// falling edge, away from the active rising edge. Expected values are
// hand-computed constants or simple counters kept by the bench.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_eq;
    logic         out_carry;
    logic         out_of;
    logic         out_zero;
    logic         sticky_clr;
    logic         sticky_of;

    int n_asserts = 0;
    int n_fail    = 0;

`ifdef ALU_STICKY_OF_EN
    localparam logic STICKY_EXP = 1'b1;
`else
    localparam logic STICKY_EXP = 1'b0;
`endif

    alu_pipe #(.WIDTH(W), .OP_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_eq     (out_eq),
        .out_carry  (out_carry),
        .out_of     (out_of),
        .out_zero   (out_zero),
        .sticky_clr (sticky_clr),
        .sticky_of  (sticky_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one beat into an idle pipeline and check its result two edges later.
    task automatic issue_and_check(input string tag, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] exp_s, input logic exp_eq,
                                   input logic exp_c, input logic exp_of,
                                   input logic exp_z);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, ".s"},     64'(out_s),     64'(exp_s));
        check({tag, ".eq"},    64'(out_eq),    64'(exp_eq));
        check({tag, ".carry"}, 64'(out_carry), 64'(exp_c));
        check({tag, ".of"},    64'(out_of),    64'(exp_of));
        check({tag, ".zero"},  64'(out_zero),  64'(exp_z));
    endtask

    initial begin
        int j;
        int e;
        logic acc;
        logic fire;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_op      = 3'b000;
        out_ready  = 1'b1;
        sticky_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst.in_ready",  64'(in_ready),  64'(1'b1));
        check("rst.out_valid", 64'(out_valid), 64'(1'b0));
        check("rst.out_s",     64'(out_s),     64'(0));
        check("rst.flags",     64'({out_eq, out_carry, out_of, out_zero}), 64'(0));
        check("rst.sticky",    64'(sticky_of), 64'(0));

        // Directed ALU vectors
        issue_and_check("xor",  3'b010, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 0, 0, 0, 0);
        issue_and_check("add_of", 3'b100, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0);
        @(negedge clk);
        check("sticky_after_of", 64'(sticky_of), 64'(STICKY_EXP));
        issue_and_check("sub_eq", 3'b101, 32'd5, 32'd5, 32'h0, 1, 1, 0, 1);
        @(negedge clk);
        check("sticky_persist", 64'(sticky_of), 64'(STICKY_EXP));
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        check("sticky_cleared", 64'(sticky_of), 64'(0));

        issue_and_check("slt",  3'b110, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 0);
        issue_and_check("sltu", 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0, 0, 1);
        issue_and_check("and",  3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0, 0, 0, 0);
        issue_and_check("or",   3'b001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0, 0, 0, 0);
        issue_and_check("nor",  3'b011, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h000F_000F, 0, 0, 0, 0);
        issue_and_check("sub_borrow", 3'b101, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        issue_and_check("sub_of",  3'b101, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 1, 0);
        issue_and_check("add_wrap", 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, 0, 1);

        // Set and clear on the same edge: set wins.
        sticky_clr = 1'b1;
        @(negedge clk);
        check("sticky_clr_idle", 64'(sticky_of), 64'(0));
        issue_and_check("add_of2", 3'b100, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1, 0, 1, 0);
        @(negedge clk);
        sticky_clr = 1'b0;
        check("sticky_set_wins", 64'(sticky_of), 64'(STICKY_EXP));

        // 8 back-to-back beats, results on consecutive cycles in order.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check("stream.valid", 64'(out_valid), 64'(1'b1));
                check("stream.s",     64'(out_s),     64'(100 + k - 2));
            end
            if (k < 8) begin
                check("stream.in_ready", 64'(in_ready), 64'(1'b1));
                in_valid = 1'b1;
                in_op    = 3'b100;
                in_a     = 32'(k);
                in_b     = 32'd100;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("stream.drained", 64'(out_valid), 64'(1'b0));

        // Backpressure: out_ready low for 5 cycles while 6 beats are offered.
        j = 0;
        e = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid  = (j < 6);
            in_op     = 3'b100;
            in_a      = 32'(200 + j);
            in_b      = 32'd0;
            #1;
            if (c >= 2 && c <= 4) begin
                check("bp.in_ready_low", 64'(in_ready),  64'(1'b0));
                check("bp.hold_valid",   64'(out_valid), 64'(1'b1));
                check("bp.hold_s",       64'(out_s),     64'(200));
            end
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                check("bp.order", 64'(out_s), 64'(200 + e));
                e++;
            end
            if (acc) j++;
        end
        check("bp.accepted",  64'(j), 64'(6));
        check("bp.delivered", 64'(e), 64'(6));
        check("bp.drained",   64'(out_valid), 64'(1'b0));

        // Reset with two beats in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_op    = 3'b010;
            in_a     = 32'(k + 1);
            in_b     = 32'h0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("inflight.valid", 64'(out_valid), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async.valid", 64'(out_valid), 64'(1'b0));
        check("rst_async.s",     64'(out_s),     64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst.valid", 64'(out_valid), 64'(1'b0));
        end
        check("post_rst.in_ready", 64'(in_ready), 64'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
